sdram_init_mon: RTL
===================

# sdram_init_mon

Device-side responder for the SDRAM power-up initialization interface. It samples the {CS#, RAS#, CAS#, WE#}/bank/address bus that the controller drives and checks the JEDEC-style init sequence: power-up wait, precharge-all, N auto refreshes, then mode register set. It latches the programmed mode fields and raises a ready flag, or a sticky error with a cause code. It sits in the SDRAM device model and in the controller's simulation and assertion harness.

## Interface
Parameters:
- T_WAIT, 20000: power-up idle cycles before any command is legal.
- T_RP, 3: minimum cycles from PRE to the next command.
- T_RFC, 7: minimum cycles from AR to the next command.
- T_MRD, 2: minimum cycles from MRS to the next command.
- N_AR, 2: minimum number of AR commands before MRS.

Ports:
- mon_clk  in  1  clock.
- mon_rst  in  1  reset. Reset is synchronous and active-high.
- mon_cmd  in  4  {CS#, RAS#, CAS#, WE#}.
- mon_bank  in  2  bank address.
- mon_addr  in  13  address A12..A0.
- mon_ready  out  1  init sequence completed legally; sticky.
- mon_err  out  1  protocol violation detected; sticky.
- mon_err_code  out  3  first error cause: 1=EARLY, 2=SEQ, 3=TIMING, 4=MODE.
- mon_err_cmd  out  4  mon_cmd sampled in the offending cycle.
- mon_cas_lat  out  3  latched A6..A4.
- mon_burst_len  out  3  latched A2..A0.
- mon_burst_type  out  1  latched A3.
- mon_wr_mode  out  1  latched A9.
- mon_ar_cnt  out  4  accepted AR count, saturating at 15.

## Operation
- Command decode:
  - mon_cmd[3]=1 (deselect) or 4'b0111 is NOP.
  - 0010 is PRE, 0001 is AR, 0000 is MRS.
  - Any other code (ACT, RD, WR, BST) is illegal before ready, cause SEQ.
- Cycle index k counts rising edges since mon_rst was last sampled low, starting at 0.
  - A power counter saturates at T_WAIT.
  - A gap counter clears on every accepted non-NOP command, increments otherwise, and saturates at 15.
- States:
  - PWR: a non-NOP command at k < T_WAIT is EARLY. When the counter reaches T_WAIT, go to W_PRE.
  - W_PRE: PRE with A10=1 goes to W_AR. Any other non-NOP command, including PRE with A10=0, is SEQ.
  - W_AR: AR increments mon_ar_cnt.
    - MRS with mon_ar_cnt ≥ N_AR goes to W_MRD. MRS with fewer ARs, or PRE, is SEQ.
    - Extra ARs beyond N_AR are legal.
  - W_MRD: any non-NOP command before the gap reaches T_MRD is TIMING. Once the gap reaches T_MRD, go to READY.
  - READY: the bus is ignored; all outputs hold until reset.
  - ERR: the bus is ignored; all outputs hold until reset.
- Spacing rule: a command at k2 following an accepted command at k1 requires k2−k1 ≥ T_RP, T_RFC or T_MRD, according to the earlier command. Otherwise the cause is TIMING.
- MRS legality:
  - bank = 00.
  - A12..A10 = 0 and A8..A7 = 0.
  - CAS latency is 010 or 011.
  - Burst length is not 100, 101 or 110.
  - Otherwise the cause is MODE.
  - Mode outputs load only on a legal MRS.
- Simultaneous causes: priority is EARLY > SEQ > TIMING > MODE. Only the first error is recorded; the block enters ERR.

## Timing
- All outputs are registered and reflect a command sampled at edge k starting from cycle k+1.
- mon_ready is high from cycle k_MRS + T_MRD onward.
- Reset values:
  - mon_ready=0, mon_err=0, mon_err_code=0, mon_err_cmd=4'b0111.
  - mon_cas_lat=0, mon_burst_len=0, mon_burst_type=0, mon_wr_mode=0, mon_ar_cnt=0.
- Reset mid-sequence clears all state and restarts the power wait at k=0 on the next cycle.
- mon_ready and mon_err are never both high.

## Test plan
All scenarios use T_WAIT=100 and other parameters at default.
1. Golden sequence:
   - Stimulus: PRE (A10=1) at k=100, AR at k=103, AR at k=110, MRS bank 0 addr 13'h0037 at k=117.
   - Response: mon_ready=1 from k=119; cas_lat=011, burst_len=111, burst_type=0, wr_mode=0, ar_cnt=2, mon_err=0.
2. Early command:
   - Stimulus: PRE at k=50.
   - Response: mon_err=1 at k=51, code=1, err_cmd=0010; later legal commands do not change outputs.
3. Refresh spacing violation:
   - Stimulus: golden sequence with the second AR at k=108.
   - Response: code=3 at k=109, ar_cnt=1, mon_ready stays 0.
4. Sequence errors:
   - Stimulus A: PRE with A10=0 at k=100. Response: code=2.
   - Stimulus B: separate run, MRS right after a single AR. Response: code=2, err_cmd=0000.
5. Mode error:
   - Stimulus: golden sequence with MRS addr 13'h0017 (CAS latency 001).
   - Response: code=4, mode outputs remain 0, mon_ready=0.
6. Reset mid-sequence:
   - Stimulus: mon_rst high at k=105 for one cycle, then PRE 60 cycles later.
   - Response: all outputs return to reset values; the PRE gives code=1.

Source files
------------

// File: rtl/sdram_init_mon.sv
// sdram_init_mon: passive monitor for the SDRAM power-up init sequence (PRE-all, auto refreshes, MRS).
// Latches the programmed mode fields on success, or the first protocol error with its cause and command.
module sdram_init_mon #(
    parameter int T_WAIT = 20000,
    parameter int T_RP   = 3,
    parameter int T_RFC  = 7,
    parameter int T_MRD  = 2,
    parameter int N_AR   = 2
) (
    input  logic        mon_clk,
    input  logic        mon_rst,
    input  logic [3:0]  mon_cmd,
    input  logic [1:0]  mon_bank,
    input  logic [12:0] mon_addr,
    output logic        mon_ready,
    output logic        mon_err,
    output logic [2:0]  mon_err_code,
    output logic [3:0]  mon_err_cmd,
    output logic [2:0]  mon_cas_lat,
    output logic [2:0]  mon_burst_len,
    output logic        mon_burst_type,
    output logic        mon_wr_mode,
    output logic [3:0]  mon_ar_cnt
);
    localparam int PW = (T_WAIT < 1) ? 1 : $clog2(T_WAIT + 1);
    localparam logic [PW-1:0] PWR_MAX  = PW'(T_WAIT);
    localparam logic [PW-1:0] PWR_LAST = PW'((T_WAIT > 0) ? T_WAIT - 1 : 0);
    localparam logic [4:0] NEED_RP  = 5'(T_RP);
    localparam logic [4:0] NEED_RFC = 5'(T_RFC);
    localparam logic [4:0] NEED_MRD = 5'(T_MRD);
    // The spacing to the MRS is one larger at the next edge, which is when ready becomes visible.
    localparam logic [4:0] MRD_DONE = 5'((T_MRD > 1) ? T_MRD - 1 : 0);
    localparam logic [3:0] NEED_AR  = 4'(N_AR);
    localparam bit MRS_DIRECT = (T_MRD <= 1);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_EARLY  = 3'd1;
    localparam logic [2:0] ERR_SEQ    = 3'd2;
    localparam logic [2:0] ERR_TIMING = 3'd3;
    localparam logic [2:0] ERR_MODE   = 3'd4;

    typedef enum logic [2:0] {
        ST_PWR   = 3'd0,
        ST_W_PRE = 3'd1,
        ST_W_AR  = 3'd2,
        ST_W_MRD = 3'd3,
        ST_READY = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    function automatic logic f_is_nop(input logic [3:0] cmd);
        return cmd[3] || (cmd == CMD_NOP);
    endfunction

    function automatic logic f_mode_ok(input logic [1:0] bank, input logic [12:0] addr);
        logic bl_ok;
        logic cl_ok;
        bl_ok = (addr[2:0] != 3'b100) && (addr[2:0] != 3'b101) && (addr[2:0] != 3'b110);
        cl_ok = (addr[6:4] == 3'b010) || (addr[6:4] == 3'b011);
        return (bank == 2'b00) && (addr[12:10] == 3'b000) && (addr[8:7] == 2'b00) && cl_ok && bl_ok;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_pwr_cnt;
    logic [3:0]      r_gap;
    logic [4:0]      r_need;
    logic            r_ready;
    logic            r_err;
    logic [2:0]      r_err_code;
    logic [3:0]      r_err_cmd;
    logic [2:0]      r_cas_lat;
    logic [2:0]      r_burst_len;
    logic            r_burst_type;
    logic            r_wr_mode;
    logic [3:0]      r_ar_cnt;

    logic            w_nop;
    logic            w_is_pre;
    logic            w_is_ar;
    logic            w_is_mrs;
    logic            w_legal_op;
    logic            w_mode_ok;
    logic [4:0]      w_dist;
    logic            w_too_soon;
    logic            w_fault;
    logic [2:0]      w_fault_code;
    logic            w_accept;
    logic [4:0]      w_need_nxt;
    logic            w_ar_inc;
    logic            w_mode_load;

    assign w_nop      = f_is_nop(mon_cmd);
    assign w_is_pre   = (mon_cmd == CMD_PRE);
    assign w_is_ar    = (mon_cmd == CMD_AR);
    assign w_is_mrs   = (mon_cmd == CMD_MRS);
    assign w_legal_op = w_is_pre || w_is_ar || w_is_mrs;
    assign w_mode_ok  = f_mode_ok(mon_bank, mon_addr);
    // r_gap counts edges after the last accepted command, so the distance at this edge is one more.
    assign w_dist     = {1'b0, r_gap} + 5'd1;
    assign w_too_soon = (w_dist < r_need);

    // Next-state, error classification and update strobes for the current bus command.
    always_comb begin
        w_state_nxt  = r_state;
        w_fault      = 1'b0;
        w_fault_code = ERR_NONE;
        w_accept     = 1'b0;
        w_need_nxt   = r_need;
        w_ar_inc     = 1'b0;
        w_mode_load  = 1'b0;
        case (r_state)
            ST_PWR: begin
                if (!w_nop) begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_EARLY;
                    w_state_nxt  = ST_ERR;
                end else if (r_pwr_cnt == PWR_LAST) begin
                    w_state_nxt = ST_W_PRE;
                end else begin
                    w_state_nxt = ST_PWR;
                end
            end
            ST_W_PRE: begin
                if (w_nop) begin
                    w_state_nxt = ST_W_PRE;
                end else if (w_is_pre && mon_addr[10]) begin
                    if (w_too_soon) begin
                        w_fault      = 1'b1;
                        w_fault_code = ERR_TIMING;
                        w_state_nxt  = ST_ERR;
                    end else begin
                        w_accept    = 1'b1;
                        w_need_nxt  = NEED_RP;
                        w_state_nxt = ST_W_AR;
                    end
                end else begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_SEQ;
                    w_state_nxt  = ST_ERR;
                end
            end
            ST_W_AR: begin
                if (w_nop) begin
                    w_state_nxt = ST_W_AR;
                end else if (w_is_ar) begin
                    if (w_too_soon) begin
                        w_fault      = 1'b1;
                        w_fault_code = ERR_TIMING;
                        w_state_nxt  = ST_ERR;
                    end else begin
                        w_accept    = 1'b1;
                        w_ar_inc    = 1'b1;
                        w_need_nxt  = NEED_RFC;
                        w_state_nxt = ST_W_AR;
                    end
                end else if (w_is_mrs && (r_ar_cnt >= NEED_AR)) begin
                    if (w_too_soon) begin
                        w_fault      = 1'b1;
                        w_fault_code = ERR_TIMING;
                        w_state_nxt  = ST_ERR;
                    end else if (!w_mode_ok) begin
                        w_fault      = 1'b1;
                        w_fault_code = ERR_MODE;
                        w_state_nxt  = ST_ERR;
                    end else begin
                        w_accept    = 1'b1;
                        w_mode_load = 1'b1;
                        w_need_nxt  = NEED_MRD;
                        w_state_nxt = MRS_DIRECT ? ST_READY : ST_W_MRD;
                    end
                end else begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_SEQ;
                    w_state_nxt  = ST_ERR;
                end
            end
            ST_W_MRD: begin
                if (!w_nop) begin
                    w_fault      = 1'b1;
                    w_fault_code = w_legal_op ? ERR_TIMING : ERR_SEQ;
                    w_state_nxt  = ST_ERR;
                end else if (w_dist >= MRD_DONE) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_state_nxt = ST_W_MRD;
                end
            end
            ST_READY, ST_ERR: begin
                w_state_nxt = r_state;
            end
            default: begin
                w_fault      = 1'b1;
                w_fault_code = ERR_SEQ;
                w_state_nxt  = ST_ERR;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge mon_clk) begin
        if (mon_rst) begin
            r_state      <= ST_PWR;
            r_pwr_cnt    <= '0;
            r_gap        <= 4'd0;
            r_need       <= 5'd0;
            r_ready      <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_err_cmd    <= CMD_NOP;
            r_cas_lat    <= 3'd0;
            r_burst_len  <= 3'd0;
            r_burst_type <= 1'b0;
            r_wr_mode    <= 1'b0;
            r_ar_cnt     <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_need  <= w_need_nxt;
            r_ready <= (w_state_nxt == ST_READY);
            r_err   <= (w_state_nxt == ST_ERR);
            if (r_pwr_cnt != PWR_MAX) begin
                r_pwr_cnt <= r_pwr_cnt + PW'(1);
            end
            if (w_accept) begin
                r_gap <= 4'd0;
            end else if (r_gap != 4'hF) begin
                r_gap <= r_gap + 4'd1;
            end
            if (w_ar_inc && (r_ar_cnt != 4'hF)) begin
                r_ar_cnt <= r_ar_cnt + 4'd1;
            end
            if (w_mode_load) begin
                r_cas_lat    <= mon_addr[6:4];
                r_burst_len  <= mon_addr[2:0];
                r_burst_type <= mon_addr[3];
                r_wr_mode    <= mon_addr[9];
            end
            if (w_fault) begin
                r_err_code <= w_fault_code;
                r_err_cmd  <= mon_cmd;
            end
        end
    end

    assign mon_ready      = r_ready;
    assign mon_err        = r_err;
    assign mon_err_code   = r_err_code;
    assign mon_err_cmd    = r_err_cmd;
    assign mon_cas_lat    = r_cas_lat;
    assign mon_burst_len  = r_burst_len;
    assign mon_burst_type = r_burst_type;
    assign mon_wr_mode    = r_wr_mode;
    assign mon_ar_cnt     = r_ar_cnt;

    sdram_init_mon_chk u_chk (
        .i_clk      (mon_clk),
        .i_rst      (mon_rst),
        .i_ready    (r_ready),
        .i_err      (r_err),
        .i_err_code (r_err_code)
    );
endmodule

// sdram_init_mon_chk: invariants on the monitor's status outputs.
module sdram_init_mon_chk (
    input logic       i_clk,
    input logic       i_rst,
    input logic       i_ready,
    input logic       i_err,
    input logic [2:0] i_err_code
);
    // Ready and error exclude each other, both stay set until reset, and an error always has a cause.
    a_excl:         assert property (@(posedge i_clk) !(i_ready && i_err));
    a_ready_sticky: assert property (@(posedge i_clk) (i_ready && !i_rst) |=> i_ready);
    a_err_sticky:   assert property (@(posedge i_clk) (i_err && !i_rst) |=> i_err);
    a_err_cause:    assert property (@(posedge i_clk) i_err |-> (i_err_code != 3'd0));
endmodule
